// File: rtl/lsb_mem_unit.sv
`timescale 1ns/1ps
// lsb_mem_unit: memory-side responder for the load/store buffer.
// Takes one load/store descriptor at a time, breaks it into byte-wide
// accesses on the single-port RAM/IO bus, and returns a tagged completion
// pulse. Load data is returned zero-extended; stores return 0.
module lsb_mem_unit #(
  parameter int         LSB_CAP_BIT = 3,
  parameter logic [1:0] IO_ADDR_HI  = 2'b11
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   req_in,
  input  logic [LSB_CAP_BIT-1:0] pos_in,
  input  logic                   ls_in,
  input  logic [1:0]             len_in,
  input  logic [31:0]            addr_in,
  input  logic [31:0]            val_in,
  output logic                   busy,
  output logic                   finished,
  output logic [LSB_CAP_BIT-1:0] pos_out,
  output logic [31:0]            val_out,
  input  logic                   io_buffer_full,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]             state_reg;
  logic [1:0]             cnt_reg;
  logic [1:0]             len_reg;
  logic [31:0]            addr_reg;
  logic [31:0]            data_reg;
  logic [LSB_CAP_BIT-1:0] pos_reg;
  logic                   wr_q;
  // Set when the ROB flushes while a committed store is still draining;
  // the store completes on the bus but never reports back.
  logic                   flush_reg;

  logic [1:0]  last_cnt;
  logic [1:0]  next_cnt;
  logic [31:0] cur_addr;
  logic [31:0] next_addr;
  logic        cur_is_io;
  logic        in_is_io;
  logic        suppress;
  logic [7:0]  data_bytes [4];
  logic [31:0] ld_word;

  // Index of the final byte for the latched access size (11 behaves as word).
  always_comb begin
    last_cnt = 2'd3;
    case (len_reg)
      2'b00:   last_cnt = 2'd0;
      2'b01:   last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end

  assign next_cnt  = cnt_reg + 2'd1;
  assign cur_addr  = addr_reg + {30'd0, cnt_reg};
  assign next_addr = cur_addr + 32'd1;
  assign cur_is_io = (cur_addr[17:16] == IO_ADDR_HI);
  assign in_is_io  = (addr_in[17:16] == IO_ADDR_HI);
  assign suppress  = flush_reg || clear;

  // Byte view of the data buffer, and the final load word: the byte arriving
  // this cycle comes straight from mem_din, bytes beyond the size are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      localparam logic [1:0] BI = gi;
      assign data_bytes[gi] = data_reg[gi*8 +: 8];
      assign ld_word[gi*8 +: 8] = (BI > last_cnt) ? 8'h00 :
                                  ((BI == cnt_reg) ? mem_din : data_bytes[gi]);
    end
  endgenerate

  // Busy must rise in the same cycle as a request so the LSB never issues
  // a second one on top of it.
  assign busy   = (state_reg != ST_IDLE) || req_in;
  assign mem_wr = wr_q && rdy_in;

  // Main sequencer: accept, serialise bytes, pulse completion, return to idle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 2'd0;
      len_reg   <= 2'd0;
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
      pos_reg   <= '0;
      wr_q      <= 1'b0;
      flush_reg <= 1'b0;
      finished  <= 1'b0;
      pos_out   <= '0;
      val_out   <= 32'd0;
      mem_a     <= 32'd0;
      mem_dout  <= 8'd0;
    end else if (rdy_in) begin
      case (state_reg)
        ST_IDLE: begin
          finished <= 1'b0;
          wr_q     <= 1'b0;
          if (req_in && !clear) begin
            pos_reg   <= pos_in;
            len_reg   <= len_in;
            addr_reg  <= addr_in;
            cnt_reg   <= 2'd0;
            flush_reg <= 1'b0;
            if (!ls_in) begin
              data_reg  <= 32'd0;
              mem_a     <= addr_in;
              state_reg <= ST_READ;
            end else begin
              data_reg  <= val_in;
              state_reg <= ST_WRITE;
              if (in_is_io && io_buffer_full) begin
                wr_q <= 1'b0;
              end else begin
                wr_q     <= 1'b1;
                mem_a    <= addr_in;
                mem_dout <= val_in[7:0];
              end
            end
          end
        end

        ST_READ: begin
          if (clear) begin
            state_reg <= ST_IDLE;
            finished  <= 1'b0;
            wr_q      <= 1'b0;
          end else begin
            data_reg[{cnt_reg, 3'b000} +: 8] <= mem_din;
            if (cnt_reg == last_cnt) begin
              finished  <= 1'b1;
              pos_out   <= pos_reg;
              val_out   <= ld_word;
              state_reg <= ST_DONE;
            end else begin
              mem_a   <= next_addr;
              cnt_reg <= next_cnt;
            end
          end
        end

        ST_WRITE: begin
          if (clear) begin
            flush_reg <= 1'b1;
          end
          if (wr_q) begin
            // The byte currently on the bus is written at this edge.
            if (cnt_reg == last_cnt) begin
              wr_q      <= 1'b0;
              state_reg <= ST_DONE;
              finished  <= !suppress;
              if (!suppress) begin
                pos_out <= pos_reg;
                val_out <= 32'd0;
              end
            end else begin
              mem_a    <= next_addr;
              mem_dout <= data_bytes[next_cnt];
              cnt_reg  <= next_cnt;
            end
          end else if (!(cur_is_io && io_buffer_full)) begin
            // IO buffer has room again: start the pending byte.
            wr_q     <= 1'b1;
            mem_a    <= cur_addr;
            mem_dout <= data_bytes[cnt_reg];
          end
        end

        default: begin
          // Completion cycle: drop the pulse and go back to idle.
          finished  <= 1'b0;
          wr_q      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_mem_unit.sv
`timescale 1ns/1ps
// Testbench for lsb_mem_unit: bench-owned byte RAM, a reference memory
// image updated from access semantics, and per-scenario tasks.
module tb_lsb_mem_unit;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        req_in = 1'b0;
  logic [2:0]  pos_in = 3'd0;
  logic        ls_in = 1'b0;
  logic [1:0]  len_in = 2'd0;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] val_in = 32'd0;
  logic        busy;
  logic        finished;
  logic [2:0]  pos_out;
  logic [31:0] val_out;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int errors = 0;
  int checks = 0;

  // Bench RAM (4 KiB, aliased on the low 12 address bits) and its reference.
  logic [7:0]  ram [4096];
  logic [7:0]  ref_mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_a = 12'd0;
  logic [7:0]  pl_d = 8'd0;
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];

  lsb_mem_unit #(.LSB_CAP_BIT(3), .IO_ADDR_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .req_in(req_in), .pos_in(pos_in), .ls_in(ls_in), .len_in(len_in),
    .addr_in(addr_in), .val_in(val_in), .busy(busy), .finished(finished),
    .pos_out(pos_out), .val_out(val_out), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk_in) begin
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wa_q.push_back(mem_a);
      wd_q.push_back(mem_dout);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] len);
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  // Compare logged bus writes since index ws against addr+k / val byte k.
  task automatic check_writes(input int ws, input logic [31:0] addr,
                              input logic [31:0] val, input int n, input string name);
    logic [31:0] ea;
    logic [7:0]  ed;
    checks++;
    if (wa_q.size() - ws !== n) begin
      errors++;
      $display("FAIL %s write count: got %0d want %0d", name, wa_q.size() - ws, n);
    end else begin
      for (int k = 0; k < n; k++) begin
        ea = addr + k;
        ed = val[k*8 +: 8];
        checks++;
        if (wa_q[ws+k] !== ea || wd_q[ws+k] !== ed) begin
          errors++;
          $display("FAIL %s write %0d: got %h@%h want %h@%h", name, k,
                   wd_q[ws+k], wa_q[ws+k], ed, ea);
        end
        ref_mem[ea[11:0]] = ed;
      end
    end
  endtask

  // One full transaction with optional IO stall cycles and rdy_in hold cycles.
  task automatic run_txn(input logic ls, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] val, input logic [2:0] pos,
                         input int stall, input int hold, input string name);
    int n, act, frz, edges, ws, exp_edges;
    logic [31:0] exp_val, ea;
    n = nbytes(len);
    exp_val = 32'd0;
    if (!ls) begin
      for (int k = 0; k < n; k++) begin
        ea = addr + k;
        exp_val = exp_val | ({24'd0, ref_mem[ea[11:0]]} << (8*k));
      end
    end
    exp_edges = n + hold + ((ls && addr[17:16] == 2'b11 && stall > 0) ? stall : 0);
    ws = wa_q.size();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle busy: got %0b want 0", name, busy);
    end
    req_in = 1'b1; ls_in = ls; len_in = len; addr_in = addr; val_in = val;
    pos_in = pos; io_buffer_full = (stall > 0); clear = 1'b0; rdy_in = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy on req: got %0b want 1", name, busy);
    end
    @(posedge clk_in); #1;
    req_in = 1'b0; val_in = $urandom; addr_in = $urandom;
    act = 0; frz = 0; edges = 0;
    while (finished !== 1'b1 && edges < 64) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy mid: got %0b want 1", name, busy);
      end
      if (!ls && act < n) begin
        ea = addr + act;
        checks++;
        if (mem_a !== ea) begin
          errors++;
          $display("FAIL %s mem_a: got %h want %h", name, mem_a, ea);
        end
      end
      rdy_in = (frz < hold) ? 1'b0 : 1'b1;
      io_buffer_full = (act + 1 < stall);
      #1;
      if (!rdy_in) begin
        frz++;
        checks++;
        if (mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL %s mem_wr when not ready: got %0b want 0", name, mem_wr);
        end
      end else begin
        act++;
      end
      @(posedge clk_in); #1;
      edges++;
    end
    rdy_in = 1'b1; io_buffer_full = 1'b0;
    checks++;
    if (finished !== 1'b1 || edges !== exp_edges) begin
      errors++;
      $display("FAIL %s latency: got fin=%0b after %0d edges want 1 after %0d",
               name, finished, edges, exp_edges);
    end
    checks++;
    if (pos_out !== pos || val_out !== exp_val || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s result: got pos=%0d val=%h busy=%0b want pos=%0d val=%h busy=1",
               name, pos_out, val_out, busy, pos, exp_val);
    end
    tick();
    checks++;
    if (finished !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got fin=%0b busy=%0b want 0 0", name, finished, busy);
    end
    if (ls) check_writes(ws, addr, val, n, name);
    else begin
      checks++;
      if (wa_q.size() !== ws) begin
        errors++;
        $display("FAIL %s load wrote bus: got %0d writes want 0", name, wa_q.size() - ws);
      end
    end
    $display("txn %s ls=%0b len=%0d addr=%h val=%h pos=%0d edges=%0d", name, ls, len,
             addr, ls ? val : val_out, pos, edges);
  endtask

  task automatic test_reset();
    checks++;
    if (finished !== 1'b0 || pos_out !== 3'd0 || val_out !== 32'd0 || mem_a !== 32'd0 ||
        mem_dout !== 8'd0 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got fin=%0b pos=%0d val=%h a=%h d=%h wr=%0b want all 0",
               finished, pos_out, val_out, mem_a, mem_dout, mem_wr);
    end
    req_in = 1'b1; #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset busy follows req: got %0b want 1", busy);
    end
    req_in = 1'b0; #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset busy idle: got %0b want 0", busy);
    end
  endtask

  task automatic test_directed();
    run_txn(1'b0, 2'b10, 32'h100, 32'd0, 3'd5, 0, 0, "lw_0x100");
    run_txn(1'b0, 2'b00, 32'h7, 32'd0, 3'd1, 0, 0, "lb_0x7");
    run_txn(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0, 3'd2, 0, 0, "lh_wrap");
    run_txn(1'b1, 2'b10, 32'h200, 32'hDEAD_BEEF, 3'd3, 0, 0, "sw_0x200");
    run_txn(1'b1, 2'b00, 32'h30000, 32'h41, 3'd4, 3, 0, "sb_io_stall");
    run_txn(1'b1, 2'b00, 32'h20000, 32'h41, 3'd6, 3, 0, "sb_nonio");
    run_txn(1'b0, 2'b10, 32'h200, 32'd0, 3'd7, 0, 0, "lw_readback");
  endtask

  task automatic test_random();
    logic        ls;
    logic [31:0] addr;
    int          stall;
    for (int i = 0; i < 24; i++) begin
      ls = $urandom_range(0, 1);
      stall = 0;
      if ($urandom_range(0, 3) == 0) begin
        addr = 32'h30000 + $urandom_range(0, 32'h7FC);
        stall = $urandom_range(0, 3);
      end else begin
        addr = $urandom_range(0, 32'h7FC);
      end
      run_txn(ls, 2'($urandom_range(0, 3)), addr, $urandom, 3'($urandom_range(0, 7)),
              stall, 0, "random");
    end
  endtask

  task automatic test_rdy_hold();
    run_txn(1'b0, 2'b01, 32'h101, 32'd0, 3'd2, 0, 2, "lh_rdy_hold");
    run_txn(1'b1, 2'b01, 32'h400, 32'h0000_A55A, 3'd3, 0, 2, "sh_rdy_hold");
  endtask

  task automatic test_clear_load();
    int fin_seen;
    req_in = 1'b1; ls_in = 1'b0; len_in = 2'b10; addr_in = 32'h100; pos_in = 3'd5;
    tick();
    req_in = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (finished !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_load idle: got fin=%0b busy=%0b want 0 0", finished, busy);
    end
    fin_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (finished === 1'b1) fin_seen++;
    end
    checks++;
    if (fin_seen !== 0) begin
      errors++;
      $display("FAIL clear_load pulse: got %0d finished cycles want 0", fin_seen);
    end
    $display("txn clear_load addr=00000100");
  endtask

  task automatic test_clear_store();
    int ws, fin_seen, cyc;
    ws = wa_q.size();
    req_in = 1'b1; ls_in = 1'b1; len_in = 2'b10; addr_in = 32'h300;
    val_in = 32'h1234_5678; pos_in = 3'd1;
    tick();
    req_in = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    fin_seen = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 12) begin
      if (finished === 1'b1) fin_seen++;
      tick();
      cyc++;
    end
    checks++;
    if (fin_seen !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_store: got fin_cycles=%0d busy=%0b want 0 0", fin_seen, busy);
    end
    check_writes(ws, 32'h300, 32'h1234_5678, 4, "clear_store");
    $display("txn clear_store addr=00000300 val=12345678");
  endtask

  task automatic test_reset_mid();
    req_in = 1'b1; ls_in = 1'b1; len_in = 2'b10; addr_in = 32'h800;
    val_in = 32'hCAFE_F00D; pos_in = 3'd6;
    tick();
    req_in = 1'b0;
    tick();
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if (finished !== 1'b0 || pos_out !== 3'd0 || val_out !== 32'd0 || mem_a !== 32'd0 ||
        mem_dout !== 8'd0 || mem_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got fin=%0b pos=%0d val=%h a=%h d=%h wr=%0b busy=%0b want all 0",
               finished, pos_out, val_out, mem_a, mem_dout, mem_wr, busy);
    end
    #2 rst_n_in = 1'b1;
    tick();
    $display("txn reset_mid addr=00000800");
    run_txn(1'b0, 2'b10, 32'h100, 32'd0, 3'd4, 0, 0, "lw_after_reset");
  endtask

  initial begin
    rst_n_in = 1'b0;
    pl_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      pl_a = 12'(i);
      case (i)
        'h100: pl_d = 8'h11;
        'h101: pl_d = 8'h22;
        'h102: pl_d = 8'h33;
        'h103: pl_d = 8'h44;
        'h007: pl_d = 8'hF0;
        default: pl_d = 8'($urandom);
      endcase
      ref_mem[i] = pl_d;
      tick();
    end
    pl_en = 1'b0;
    test_reset();
    #2 rst_n_in = 1'b1;
    tick();
    test_directed();
    test_rdy_hold();
    test_clear_load();
    test_clear_store();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
